serpent_key_sched_seq: RTL and testbench

//   Sequential Serpent-256 key schedule. Expands a 256-bit user key into the 33 128-bit

---
 rtl/serpent_pkg.sv | 33 +++
 rtl/serpent_key_sched_seq_if.sv | 21 ++
 rtl/serpent_sbox_sel.sv | 34 +++
 rtl/serpent_key_sched_seq.sv | 132 +++++++++++++
 tb/tb_serpent_key_sched_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serpent_pkg.sv
// rtl/serpent_pkg.sv - shared constants, types and S-box tables for the Serpent key schedule
package serpent_pkg;

    localparam logic [31:0] SERPENT_PHI      = 32'h9E3779B9;
    localparam int          SERPENT_NSUBKEYS = 33;
    localparam int          SERPENT_IDX_LAST = SERPENT_NSUBKEYS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } ks_state_e;

    typedef logic [5:0]                       subkey_idx_t;
    typedef logic [127:0]                     subkey_t;
    typedef subkey_t [SERPENT_NSUBKEYS-1:0]   key_store_t;

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB, 4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
        '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA, 4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
        '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF, 4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
        '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3, 4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
        '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6, 4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
        '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC, 4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
        '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB, 4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
        '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB, 4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
    };

    function automatic logic [3:0] sbox_lookup(input logic [2:0] sel, input logic [3:0] x);
        return SBOX[sel][x];
    endfunction

endpackage

// File: rtl/serpent_key_sched_seq_if.sv
// rtl/serpent_key_sched_seq_if.sv - key offer and subkey store bundle between key source and key schedule
interface serpent_key_sched_seq_if;
    import serpent_pkg::*;

    logic [255:0] key256;
    logic         key_valid;
    logic         key_ready;
    key_store_t   keys;
    logic         keys_valid;
    logic         busy;

    modport master (
        output key256, key_valid,
        input  key_ready, keys, keys_valid, busy
    );

    modport slave (
        input  key256, key_valid,
        output key_ready, keys, keys_valid, busy
    );
endinterface

// File: rtl/serpent_sbox_sel.sv
// rtl/serpent_sbox_sel.sv - bitsliced Serpent S-box S0..S7 selected by a 3-bit index
module serpent_sbox_sel
    import serpent_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    output logic [31:0] y0,
    output logic [31:0] y1,
    output logic [31:0] y2,
    output logic [31:0] y3
);

    logic [3:0] nib;

    // Bit b of the four words forms one nibble, x0 being its least significant bit.
    always_comb begin
        y0  = '0;
        y1  = '0;
        y2  = '0;
        y3  = '0;
        nib = '0;
        for (int b = 0; b < 32; b++) begin
            nib   = sbox_lookup(sel, {x3[b], x2[b], x1[b], x0[b]});
            y0[b] = nib[0];
            y1[b] = nib[1];
            y2[b] = nib[2];
            y3[b] = nib[3];
        end
    end

endmodule

// File: rtl/serpent_key_sched_seq.sv
// rtl/serpent_key_sched_seq.sv - sequential Serpent-256 key schedule, one subkey per clock into a register store
module serpent_key_sched_seq
    import serpent_pkg::*;
#(
    parameter bit CLEAR_ON_START = 1'b1
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    serpent_key_sched_seq_if.slave  ks
);

    function automatic logic [31:0] rotl11(input logic [31:0] v);
        return {v[20:0], v[31:21]};
    endfunction

    function automatic logic [31:0] prekey_next(input logic [31:0] w8, input logic [31:0] w5,
                                                input logic [31:0] w3, input logic [31:0] w1,
                                                input logic [7:0]  n);
        return rotl11(w8 ^ w5 ^ w3 ^ w1 ^ SERPENT_PHI ^ {24'd0, n});
    endfunction

    ks_state_e         state_q, state_d;
    subkey_idx_t       idx_q, idx_d;
    logic [7:0][31:0]  win_q, win_d;
    key_store_t        keys_q, keys_d;
    logic              keys_valid_q, keys_valid_d;

    logic              key_ready;
    logic              busy;
    logic              accept;
    logic              idx_last;
    logic [31:0]       nw0, nw1, nw2, nw3;
    logic [31:0]       y0, y1, y2, y3;
    logic [2:0]        sbox_sel;

    assign accept   = ks.key_valid && key_ready;
    assign idx_last = (idx_q == subkey_idx_t'(SERPENT_IDX_LAST));
    assign sbox_sel = 3'd3 - idx_q[2:0];

    // win_q[0] holds w[n-8], win_q[7] holds w[n-1]; the four new words chain through each other.
    always_comb begin
        nw0 = prekey_next(win_q[0], win_q[3], win_q[5], win_q[7], {idx_q, 2'd0});
        nw1 = prekey_next(win_q[1], win_q[4], win_q[6], nw0,      {idx_q, 2'd1});
        nw2 = prekey_next(win_q[2], win_q[5], win_q[7], nw1,      {idx_q, 2'd2});
        nw3 = prekey_next(win_q[3], win_q[6], nw0,      nw2,      {idx_q, 2'd3});
    end

    serpent_sbox_sel u_sbox (
        .sel (sbox_sel),
        .x0  (nw0),
        .x1  (nw1),
        .x2  (nw2),
        .x3  (nw3),
        .y0  (y0),
        .y1  (y1),
        .y2  (y2),
        .y3  (y3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = GEN;
            GEN:     if (idx_last) state_d = DONE;
            DONE:    if (accept)   state_d = GEN;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        key_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    key_ready = 1'b1;
            GEN:     busy      = 1'b1;
            DONE:    key_ready = 1'b1;
            default: key_ready = 1'b0;
        endcase
    end

    always_comb begin
        idx_d        = idx_q;
        win_d        = win_q;
        keys_d       = keys_q;
        keys_valid_d = keys_valid_q;
        if (accept) begin
            win_d        = ks.key256;
            idx_d        = '0;
            keys_valid_d = 1'b0;
            if (CLEAR_ON_START) begin
                keys_d = '0;
            end
        end else if (busy) begin
            keys_d[idx_q] = {y3, y2, y1, y0};
            win_d         = {nw3, nw2, nw1, nw0, win_q[7:4]};
            if (idx_last) begin
                keys_valid_d = 1'b1;
            end else begin
                idx_d = idx_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            win_q        <= '0;
            keys_q       <= '0;
            keys_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            win_q        <= win_d;
            keys_q       <= keys_d;
            keys_valid_q <= keys_valid_d;
        end
    end

    assign ks.key_ready  = key_ready;
    assign ks.busy       = busy;
    assign ks.keys       = keys_q;
    assign ks.keys_valid = keys_valid_q;

endmodule

// File: tb/tb_serpent_key_sched_seq.sv
// tb/tb_serpent_key_sched_seq.sv - bench for serpent_key_sched_seq, both CLEAR_ON_START settings side by side
module tb_serpent_key_sched_seq;

    localparam logic [31:0] PHI = 32'h9E3779B9;
    // Entry x of each S-box lives at bits [4x+3:4x].
    localparam logic [63:0] SB [8] = '{
        64'hC907_24DE_B56A_1F83, 64'h43D6_8EB1_A509_72CF,
        64'h25B0_4E1D_FAC3_9768, 64'hE57A_421D_369C_8BF0,
        64'hD7E9_A452_6B0C_38F1, 64'h176D_8E30_C9A4_B25F,
        64'h0A3D_F19E_B648_5C27, 64'h6539_AC47_B28E_0FD1
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key256;
    logic         key_valid;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_keys [33];

    serpent_key_sched_seq_if if_clr ();
    serpent_key_sched_seq_if if_keep ();

    assign if_clr.key256     = key256;
    assign if_clr.key_valid  = key_valid;
    assign if_keep.key256    = key256;
    assign if_keep.key_valid = key_valid;

    serpent_key_sched_seq #(.CLEAR_ON_START(1'b1)) dut_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (if_clr)
    );

    serpent_key_sched_seq #(.CLEAR_ON_START(1'b0)) dut_keep (
        .clk   (clk),
        .rst_n (rst_n),
        .ks    (if_keep)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic compute_ref(input logic [255:0] k);
        logic [31:0] w [140];
        logic [31:0] t;
        logic [63:0] tbl;
        logic [3:0]  nib;
        logic [3:0]  o;
        int          sel;
        for (int j = 0; j < 8; j++) w[j] = k[32*j +: 32];
        for (int n = 0; n < 132; n++) begin
            t = w[n] ^ w[n+3] ^ w[n+5] ^ w[n+7] ^ PHI ^ 32'(n);
            w[n+8] = (t << 11) | (t >> 21);
        end
        for (int i = 0; i < 33; i++) begin
            sel = (3 - i) & 7;
            tbl = SB[sel];
            exp_keys[i] = '0;
            for (int b = 0; b < 32; b++) begin
                nib = {w[8+4*i+3][b], w[8+4*i+2][b], w[8+4*i+1][b], w[8+4*i][b]};
                o   = tbl[int'(nib)*4 +: 4];
                exp_keys[i][b]    = o[0];
                exp_keys[i][32+b] = o[1];
                exp_keys[i][64+b] = o[2];
                exp_keys[i][96+b] = o[3];
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_accept(input logic [255:0] k, output int t_acc);
        int guard = 0;
        key256    = k;
        key_valid = 1'b1;
        while (if_clr.key_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        t_acc = cyc;
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL accept_timeout key_ready=%b required 1", if_clr.key_ready);
        end
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_keys_valid(output int tv);
        int guard = 0;
        while (if_clr.keys_valid !== 1'b1 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        tv = (if_clr.keys_valid === 1'b1) ? cyc : -1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key256    = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (if_clr.key_ready !== 1'b1 || if_keep.key_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_key_ready got %b/%b required 1", if_clr.key_ready, if_keep.key_ready);
        end
        checks++;
        if (if_clr.keys_valid !== 1'b0 || if_keep.keys_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_keys_valid got %b/%b required 0", if_clr.keys_valid, if_keep.keys_valid);
        end
        checks++;
        if (if_clr.busy !== 1'b0 || if_keep.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b/%b required 0", if_clr.busy, if_keep.busy);
        end
        checks++;
        if (if_clr.keys !== '0 || if_keep.keys !== '0) begin
            errors++;
            $display("FAIL reset_keys store not zero, keys[0] got %h required 0", if_clr.keys[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_gen();
        int ta;
        int tv;
        logic [255:0] k;
        do_accept(rand256(), ta);
        repeat (10) @(negedge clk);
        checks++;
        if (if_clr.busy !== 1'b1) begin
            errors++;
            $display("FAIL midgen_busy got %b required 1", if_clr.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_clr.key_ready !== 1'b1 || if_clr.busy !== 1'b0 || if_clr.keys_valid !== 1'b0 ||
            if_keep.key_ready !== 1'b1 || if_keep.busy !== 1'b0 || if_keep.keys_valid !== 1'b0) begin
            errors++;
            $display("FAIL midgen_reset_ctrl ready/busy/valid got %b%b%b required 100",
                     if_clr.key_ready, if_clr.busy, if_clr.keys_valid);
        end
        checks++;
        if (if_clr.keys !== '0 || if_keep.keys !== '0) begin
            errors++;
            $display("FAIL midgen_reset_keys keys[9] got %h required 0", if_clr.keys[9]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        k = rand256();
        compute_ref(k);
        do_accept(k, ta);
        wait_keys_valid(tv);
        checks++;
        if (tv - ta !== 34) begin
            errors++;
            $display("FAIL midgen_reaccept_latency got %0d required 34", tv - ta);
        end
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (if_clr.keys[i] !== exp_keys[i]) begin
                errors++;
                $display("FAIL midgen_reaccept_key[%0d] got %h required %h", i, if_clr.keys[i], exp_keys[i]);
            end
        end
    endtask

    task automatic test_known_key();
        int ta;
        int tv;
        logic [255:0] k;
        k = {4{64'h0123_4567_89AB_CDEF}};
        compute_ref(k);
        do_accept(k, ta);
        wait_keys_valid(tv);
        checks++;
        if (tv - ta !== 34) begin
            errors++;
            $display("FAIL known_latency got %0d required 34", tv - ta);
        end
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (if_clr.keys[i] !== exp_keys[i] || if_keep.keys[i] !== exp_keys[i]) begin
                errors++;
                $display("FAIL known_key[%0d] got %h/%h required %h", i, if_clr.keys[i], if_keep.keys[i], exp_keys[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        int t3;
        int guard;
        key256    = '0;
        key_valid = 1'b1;
        guard     = 0;
        while (if_clr.key_ready !== 1'b1 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        t1 = cyc;
        compute_ref('0);
        @(negedge clk);
        key256 = '1;
        guard  = 0;
        while (if_clr.key_ready !== 1'b1 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        t2 = cyc;
        checks++;
        if (t2 - t1 !== 34 || if_clr.keys_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept at +%0d valid=%b required +34 valid=1", t2 - t1, if_clr.keys_valid);
        end
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (if_clr.keys[i] !== exp_keys[i]) begin
                errors++;
                $display("FAIL b2b_zero_key[%0d] got %h required %h", i, if_clr.keys[i], exp_keys[i]);
            end
        end
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if (if_clr.keys_valid !== 1'b0 || if_keep.keys_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid_drop got %b/%b required 0", if_clr.keys_valid, if_keep.keys_valid);
        end
        compute_ref('1);
        wait_keys_valid(t3);
        checks++;
        if (t3 - t2 !== 34) begin
            errors++;
            $display("FAIL b2b_gap got %0d required 34", t3 - t2);
        end
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (if_keep.keys[i] !== exp_keys[i]) begin
                errors++;
                $display("FAIL b2b_ones_key[%0d] got %h required %h", i, if_keep.keys[i], exp_keys[i]);
            end
        end
    endtask

    task automatic test_clear_on_start();
        int ta;
        int tv;
        logic [127:0] old32;
        logic [255:0] k;
        old32 = exp_keys[32];
        k = rand256();
        compute_ref(k);
        do_accept(k, ta);
        checks++;
        if (if_clr.keys[32] !== '0) begin
            errors++;
            $display("FAIL clear1_keys32 got %h required 0", if_clr.keys[32]);
        end
        checks++;
        if (if_keep.keys[32] !== old32) begin
            errors++;
            $display("FAIL clear0_keys32 got %h required %h", if_keep.keys[32], old32);
        end
        checks++;
        if (if_clr.keys_valid !== 1'b0 || if_keep.keys_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_valid got %b/%b required 0", if_clr.keys_valid, if_keep.keys_valid);
        end
        wait_keys_valid(tv);
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (if_clr.keys[i] !== exp_keys[i] || if_keep.keys[i] !== exp_keys[i]) begin
                errors++;
                $display("FAIL clear_result_key[%0d] got %h/%h required %h", i, if_clr.keys[i], if_keep.keys[i], exp_keys[i]);
            end
        end
    endtask

    task automatic test_noise_during_gen();
        int ta;
        logic [255:0] k;
        k = rand256();
        compute_ref(k);
        do_accept(k, ta);
        for (int c = 0; c < 33; c++) begin
            checks++;
            if (if_clr.busy !== 1'b1 || if_clr.key_ready !== 1'b0) begin
                errors++;
                $display("FAIL noise_gen_state cycle %0d busy=%b ready=%b required 1/0", c, if_clr.busy, if_clr.key_ready);
            end
            key256    = rand256();
            key_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        key_valid = 1'b0;
        checks++;
        if (if_clr.keys_valid !== 1'b1 || cyc - ta !== 34) begin
            errors++;
            $display("FAIL noise_done valid=%b at +%0d required 1 at +34", if_clr.keys_valid, cyc - ta);
        end
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (if_clr.keys[i] !== exp_keys[i] || if_keep.keys[i] !== exp_keys[i]) begin
                errors++;
                $display("FAIL noise_key[%0d] got %h/%h required %h", i, if_clr.keys[i], if_keep.keys[i], exp_keys[i]);
            end
        end
    endtask

    task automatic test_random_keys();
        int ta;
        int tv;
        logic [255:0] k;
        for (int r = 0; r < 3; r++) begin
            k = rand256();
            compute_ref(k);
            do_accept(k, ta);
            wait_keys_valid(tv);
            checks++;
            if (tv - ta !== 34) begin
                errors++;
                $display("FAIL random%0d_latency got %0d required 34", r, tv - ta);
            end
            for (int i = 0; i < 33; i++) begin
                checks++;
                if (if_clr.keys[i] !== exp_keys[i]) begin
                    errors++;
                    $display("FAIL random%0d_key[%0d] got %h required %h", r, i, if_clr.keys[i], exp_keys[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_gen();
        test_known_key();
        test_back_to_back();
        test_clear_on_start();
        test_noise_during_gen();
        test_random_keys();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
